font_glyph_streamer: RTL and testbench
======================================

# font_glyph_streamer

Parametrised successor to the fixed 40x40 arcade font ROM. It stores glyphs as compact 8x8 bitmaps and scales them in hardware by `SCALE` in both axes. On request it streams the glyph's pixels in raster order over a valid/ready handshake. It sits between the text/score layout logic and the pixel compositor, so glyph size becomes a parameter rather than a separate ROM per size.

## Interface
Parameters:
- `SCALE`, 5, integer pixel replication factor per glyph bit, legal range 1..8. The default of 5 reproduces the existing 40x40 glyphs.
- `CODE_W`, 7, width of the character code.

Ports:
- `clk`  in  1  the single clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  1  glyph request present.
- `req_ready`  out  1  block idle; request accepted when `req_valid & req_ready`.
- `req_code`  in  `CODE_W`  character code, sampled on accept.
- `req_invert`  in  1  invert pixel polarity for this glyph, sampled on accept.
- `pix_valid`  out  1  `pix_on` is valid.
- `pix_ready`  in  1  downstream accepts the pixel.
- `pix_on`  out  1  pixel value: 1 = foreground.
- `pix_eol`  out  1  last pixel of a scaled line, i.e. column 8*SCALE-1.
- `pix_last`  out  1  last pixel of the glyph.

## Operation
- FSM states: IDLE, FETCH, LOAD, STREAM.
  - IDLE: `req_ready`=1. On accept, latch code and invert, clear all counters, go to FETCH.
  - FETCH: present ROM address {code, row[2:0]}. Go to LOAD.
  - LOAD: `row_buf` (8 bits) <= ROM data. Go to STREAM.
  - STREAM: `pix_valid`=1. Advance only on `pix_valid & pix_ready`.
- Counters: `sub_x` runs 0..SCALE-1, `col` 0..7, `sub_y` 0..SCALE-1, `row` 0..7. Each counter is `max(1,$clog2(SCALE))` or 3 bits wide.
- `pix_on` = `row_buf[7-col] ^ invert`; bit 7 is the leftmost pixel.
- Counter stepping on each accepted pixel:
  - `sub_x` increments. At SCALE-1 it wraps to 0 and `col` increments.
  - When `col`=7 and `sub_x`=SCALE-1 (end of line):
    - If `sub_y`<SCALE-1: `sub_y`++ and the same `row_buf` is replayed with no refetch.
    - Else, if `row`<7: `sub_y`=0, `row`++, go to FETCH.
    - Else (`row`=7): go to IDLE.
- `pix_eol` = STREAM & `col`=7 & `sub_x`=SCALE-1.
- `pix_last` = `pix_eol` & `row`=7 & `sub_y`=SCALE-1.
- `req_valid` outside IDLE is ignored: no queueing, no corruption of the current glyph.
- ROM contents:
  - Code 0x00 is blank.
  - Code 0x47 'G', rows 0..7: 00111100, 01100000, 11000000, 11001110, 11000110, 01100110, 00111110, 00000000.
  - Every unpopulated code reads all zeros.

## Timing
- Reset values:
  - State IDLE, so `req_ready`=1 from the first edge with `rst_n`=0.
  - `pix_valid`, `pix_on`, `pix_eol`, `pix_last` = 0.
  - Counters and `row_buf` = 0.
- Reset mid-stream abandons the glyph. The next cycle is IDLE with no pixel, `pix_last` or partial output.
- Accept in cycle 0, FETCH in cycle 1, LOAD in cycle 2, first `pix_valid` in cycle 3.
- Each glyph-row change inserts exactly 2 cycles with `pix_valid`=0 (FETCH, LOAD). Sub-line replays insert no bubble.
- With `pix_ready` held at 1, a glyph occupies 8*(2 + 8*SCALE*SCALE) cycles after the accept cycle. For SCALE=5 that is 1616 cycles.
- `req_ready` rises in the cycle after the `pix_last` handshake. The earliest back-to-back accept is that cycle.
- Backpressure: while `pix_valid & !pix_ready`, `pix_on`, `pix_eol`, `pix_last` and all counters hold stable.
- The ROM has registered output with 1-cycle latency.

## Structure
- Shared package `font_pkg`:
  - `GLYPH_W`=8, `GLYPH_H`=8.
  - The FSM state enum.
  - Named code constants (`CODE_BLANK`=7'h00, `CODE_G`=7'h47).
- Sub-module `glyph_rom`:
  - Inputs `clk`, `addr[CODE_W+2:0]`; output `row_bits[7:0]`, registered.
  - Case-table contents as in Operation.
- The top level holds the FSM, counters, `row_buf` and output logic.

## Test plan
- Reset, then 'G' at SCALE=5, invert=0, `pix_ready`=1:
  - First `pix_valid` exactly 3 cycles after accept.
  - Line 0 is pixels 0-9 =0, 10-29 =1, 30-39 =0, and `pix_eol` on pixel 39.
  - Exactly 1600 pixels, `pix_last` only on pixel 1600, 1616 cycles from accept to IDLE.
- 'G' at SCALE=1:
  - 64 pixels; line 3 = 1,1,0,0,1,1,1,0.
  - 2-cycle bubble between every line.
- Random `pix_ready` toggling (~50%) on 'G', SCALE=5:
  - Accepted pixel sequence is identical to the no-backpressure case.
  - Outputs stable while stalled.
- Code 0x12, invert=0, then invert=1:
  - 1600 zeros, then 1600 ones.
  - `req_valid` pulsed mid-glyph is ignored; `req_ready` stays 0.
- `rst_n` low for 1 cycle at pixel 700 of a 'G', then request code 0x00:
  - No further pixels from 'G'.
  - `req_ready`=1 in the cycle after reset.
  - The new glyph streams 1600 zeros with correct `pix_last`.

Source files
------------

// File: rtl/font_pkg.sv
// Shared types and constants for the glyph streamer and its ROM.
package font_pkg;
  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 8;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STREAM} state_t;

  localparam logic [6:0] CODE_BLANK = 7'h00;
  localparam logic [6:0] CODE_G     = 7'h47;
endpackage

// File: rtl/glyph_rom.sv
// 8x8 glyph bitmap ROM, one row per address, registered output (1-cycle latency).
// Bit 7 of each row is the leftmost pixel; unpopulated codes read as zero.
module glyph_rom
  import font_pkg::*;
#(
  parameter int CODE_W = 7
) (
  input  logic              clk,
  input  logic [CODE_W+2:0] addr,
  output logic [7:0]        row_bits
);
  logic [CODE_W-1:0] code;
  logic [2:0]        row;

  assign code = addr[CODE_W+2:3];
  assign row  = addr[2:0];

  // registered table lookup; anything not listed is blank
  always_ff @(posedge clk) begin
    row_bits <= 8'h00;
    if (code == CODE_W'(CODE_G)) begin
      case (row)
        3'd0:    row_bits <= 8'h3C;
        3'd1:    row_bits <= 8'h60;
        3'd2:    row_bits <= 8'hC0;
        3'd3:    row_bits <= 8'hCE;
        3'd4:    row_bits <= 8'hC6;
        3'd5:    row_bits <= 8'h66;
        3'd6:    row_bits <= 8'h3E;
        default: row_bits <= 8'h00;
      endcase
    end
  end
endmodule

// File: rtl/font_glyph_streamer.sv
// Streams an 8x8 glyph scaled by SCALE in both axes, raster order, over valid/ready.
// Each bitmap row is fetched once and replayed SCALE times; only row changes bubble.
module font_glyph_streamer
  import font_pkg::*;
#(
  parameter int SCALE  = 5,
  parameter int CODE_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CODE_W-1:0] req_code,
  input  logic              req_invert,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_on,
  output logic              pix_eol,
  output logic              pix_last
);
  localparam int             SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [SW-1:0]  SUB_MAX = SW'(SCALE - 1);
  localparam logic [2:0]     COL_MAX = 3'(GLYPH_W - 1);
  localparam logic [2:0]     ROW_MAX = 3'(GLYPH_H - 1);

  state_t            state, state_nx;
  logic [CODE_W-1:0] code;
  logic              invert;
  logic [7:0]        row_buf;
  logic [7:0]        row_bits;
  logic [SW-1:0]     sub_x, sub_y;
  logic [2:0]        col, row;
  logic              fire, line_end, row_done;

  glyph_rom #(.CODE_W(CODE_W)) u_rom (
    .clk      (clk),
    .addr     ({code, row}),
    .row_bits (row_bits)
  );

  assign req_ready = (state == IDLE);
  assign pix_valid = (state == STREAM);
  assign fire      = pix_valid & pix_ready;
  assign line_end  = (col == COL_MAX) && (sub_x == SUB_MAX);
  assign row_done  = line_end && (sub_y == SUB_MAX);
  assign pix_eol   = pix_valid & line_end;
  assign pix_last  = pix_eol & (row == ROW_MAX) & (sub_y == SUB_MAX);
  assign pix_on    = pix_valid & (row_buf[3'd7 - col] ^ invert);

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next state: a row needs a refetch only after its last replayed line
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = FETCH;
      FETCH:   state_nx = LOAD;
      LOAD:    state_nx = STREAM;
      STREAM:  if (fire && row_done) state_nx = (row == ROW_MAX) ? IDLE : FETCH;
      default: state_nx = IDLE;
    endcase
  end

  // request latch, row buffer and raster counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code    <= '0;
      invert  <= 1'b0;
      row_buf <= 8'h00;
      sub_x   <= '0;
      sub_y   <= '0;
      col     <= 3'd0;
      row     <= 3'd0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          code   <= req_code;
          invert <= req_invert;
          sub_x  <= '0;
          sub_y  <= '0;
          col    <= 3'd0;
          row    <= 3'd0;
        end
        LOAD: row_buf <= row_bits;
        STREAM: if (fire) begin
          if (sub_x == SUB_MAX) begin
            sub_x <= '0;
            if (col == COL_MAX) begin
              col <= 3'd0;
              if (sub_y == SUB_MAX) begin
                sub_y <= '0;
                if (row != ROW_MAX) row <= row + 3'd1;
              end else begin
                sub_y <= sub_y + 1'b1;
              end
            end else begin
              col <= col + 3'd1;
            end
          end else begin
            sub_x <= sub_x + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_font_glyph_streamer.sv
// Directed bench: a SCALE=5 and a SCALE=1 instance share inputs; sel picks which is observed.
module tb_font_glyph_streamer;
  logic       clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_invert = 1'b0, pix_ready = 1'b0;
  logic [6:0] req_code = 7'h00;
  logic       rdy5, val5, on5, eol5, last5;
  logic       rdy1, val1, on1, eol1, last1;
  logic       sel = 1'b0;
  logic       o_ready, o_valid, o_on, o_eol, o_last;
  int         checks = 0, failures = 0;

  bit rec_on [2000];
  bit rec_eol[2000];
  bit rec_last[2000];
  int npix, first_cyc, last_cyc, done_cyc, bubbles, stalls, stable_err;

  always #5 clk = ~clk;

  font_glyph_streamer #(.SCALE(5), .CODE_W(7)) dut5 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy5),
    .req_code(req_code), .req_invert(req_invert), .pix_valid(val5),
    .pix_ready(pix_ready), .pix_on(on5), .pix_eol(eol5), .pix_last(last5));

  font_glyph_streamer #(.SCALE(1), .CODE_W(7)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1),
    .req_code(req_code), .req_invert(req_invert), .pix_valid(val1),
    .pix_ready(pix_ready), .pix_on(on1), .pix_eol(eol1), .pix_last(last1));

  assign o_ready = sel ? rdy1  : rdy5;
  assign o_valid = sel ? val1  : val5;
  assign o_on    = sel ? on1   : on5;
  assign o_eol   = sel ? eol1  : eol5;
  assign o_last  = sel ? last1 : last5;

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] g_row(input int r);
    case (r)
      0: return 8'b00111100;
      1: return 8'b01100000;
      2: return 8'b11000000;
      3: return 8'b11001110;
      4: return 8'b11000110;
      5: return 8'b01100110;
      6: return 8'b00111110;
      default: return 8'b00000000;
    endcase
  endfunction

  // Issue one request at the current negedge (block must be idle) and record the
  // accepted pixels. Cycle 0 is the accept cycle. Stops on return to idle, on
  // reaching abort_at accepted pixels, or after a cycle budget.
  task automatic run_glyph(input logic [6:0] code, input logic inv, input bit rnd,
                           input int abort_at, input int pulse_at);
    bit p_on, p_eol, p_last, prev_stall;
    prev_stall = 0; p_on = 0; p_eol = 0; p_last = 0;
    npix = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
    bubbles = 0; stalls = 0; stable_err = 0;
    chk("req_ready_idle", o_ready, 1);
    req_code = code; req_invert = inv; req_valid = 1'b1; pix_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_code = 7'h47; req_invert = ~inv;
    for (int cyc = 1; cyc < 8000; cyc++) begin
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      req_valid = (cyc == pulse_at);
      if (prev_stall && (o_valid !== 1'b1 || o_on !== p_on || o_eol !== p_eol || o_last !== p_last))
        stable_err++;
      if (o_valid && first_cyc < 0) first_cyc = cyc;
      if (!o_valid && first_cyc >= 0 && !o_ready) bubbles++;
      if (o_valid && pix_ready) begin
        if (npix < 2000) begin
          rec_on[npix] = o_on; rec_eol[npix] = o_eol; rec_last[npix] = o_last;
        end
        if (o_last) last_cyc = cyc;
        npix++;
      end
      if (o_valid && !pix_ready) stalls++;
      prev_stall = o_valid && !pix_ready;
      p_on = o_on; p_eol = o_eol; p_last = o_last;
      if (o_ready) begin done_cyc = cyc; break; end
      if (abort_at > 0 && npix == abort_at) break;
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  // Compare recorded pixels against the bitmap table scaled by s.
  task automatic verify(input string tag, input logic [6:0] code, input logic inv,
                        input int s, input int n_exp);
    int errs, w, x, line;
    logic [7:0] r;
    bit e_on;
    errs = 0; w = 8 * s;
    chk({tag, "_npix"}, npix, n_exp);
    for (int k = 0; k < n_exp && k < 2000; k++) begin
      x = k % w; line = k / w;
      r = (code == 7'h47) ? g_row(line / s) : 8'h00;
      e_on = r[7 - x / s] ^ inv;
      if (rec_on[k] != e_on || rec_eol[k] != (x == w - 1) || rec_last[k] != (k == n_exp - 1))
        errs++;
    end
    chk({tag, "_pixel_errs"}, errs, 0);
  endtask

  initial begin
    logic [39:0] l0;
    logic [7:0]  l3;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready5", rdy5, 1);
    chk("rst_valid5", val5, 0);
    chk("rst_on5",    on5,  0);
    chk("rst_eol5",   eol5, 0);
    chk("rst_last5",  last5, 0);
    chk("rst_ready1", rdy1, 1);
    chk("rst_valid1", val1, 0);
    rst_n = 1'b1;

    // 'G' at SCALE=5, no backpressure
    run_glyph(7'h47, 1'b0, 1'b0, 0, 0);
    chk("g5_first_cyc", first_cyc, 3);
    chk("g5_last_cyc",  last_cyc, 1616);
    chk("g5_done_cyc",  done_cyc, 1617);
    chk("g5_bubbles",   bubbles, 14);
    l0 = '0;
    for (int k = 0; k < 40; k++) l0 = {l0[38:0], rec_on[k]};
    chk("g5_line0", l0, 40'h003FFFFC00);
    chk("g5_eol_39", rec_eol[39], 1);
    chk("g5_eol_38", rec_eol[38], 0);
    verify("g5", 7'h47, 1'b0, 5, 1600);

    // back-to-back, random backpressure
    run_glyph(7'h47, 1'b0, 1'b1, 0, 0);
    verify("g5_bp", 7'h47, 1'b0, 5, 1600);
    chk("g5_bp_stable_errs", stable_err, 0);
    chk("g5_bp_stalls_seen", stalls > 0, 1);

    // unpopulated code, both polarities, with a stray request mid-glyph
    run_glyph(7'h12, 1'b0, 1'b0, 0, 100);
    verify("c12_inv0", 7'h12, 1'b0, 5, 1600);
    chk("c12_inv0_last_cyc", last_cyc, 1616);
    run_glyph(7'h12, 1'b1, 1'b0, 0, 900);
    verify("c12_inv1", 7'h12, 1'b1, 5, 1600);
    chk("c12_inv1_last_cyc", last_cyc, 1616);

    // reset at pixel 700 of a 'G', then a blank glyph
    run_glyph(7'h47, 1'b0, 1'b0, 700, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_valid", o_valid, 0);
    chk("abort_last",  o_last, 0);
    chk("abort_ready", o_ready, 1);
    rst_n = 1'b1;
    run_glyph(7'h00, 1'b0, 1'b0, 0, 0);
    verify("blank", 7'h00, 1'b0, 5, 1600);
    chk("blank_first_cyc", first_cyc, 3);
    chk("blank_last_cyc",  last_cyc, 1616);

    // 'G' at SCALE=1
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sel = 1'b1;
    run_glyph(7'h47, 1'b0, 1'b0, 0, 0);
    verify("g1", 7'h47, 1'b0, 1, 64);
    l3 = '0;
    for (int k = 24; k < 32; k++) l3 = {l3[6:0], rec_on[k]};
    chk("g1_line3", l3, 8'b11001110);
    chk("g1_first_cyc", first_cyc, 3);
    chk("g1_last_cyc",  last_cyc, 80);
    chk("g1_bubbles",   bubbles, 14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
